// File: rtl/mac16_pkg.sv
// Shared widths, operand/accumulator types and the pipeline payload for the MAC16 stand-in.
package mac16_pkg;

  localparam int unsigned OP_W  = 16;
  localparam int unsigned EXT_W = 17;
  localparam int unsigned ACC_W = 34;

  typedef logic        [OP_W-1:0]  op_t;
  typedef logic signed [EXT_W-1:0] ext_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  // Contents of the optional product/prev register stage.
  typedef struct packed {
    acc_t prev;
    acc_t prod;
  } mac_stage_t;

  // Widen a 16-bit operand to 17 bits, sign- or zero-extending.
  function automatic ext_t ext_op(input op_t v, input bit is_signed);
    return {is_signed & v[OP_W-1], v};
  endfunction

endpackage

// File: rtl/mac16_mult.sv
// Combinational 17x17 signed multiply with per-operand signedness selection.
module mac16_mult
  import mac16_pkg::*;
#(
  parameter bit A_SIGNED = 1'b1,
  parameter bit B_SIGNED = 1'b0
) (
  input  logic        [OP_W-1:0]  a,
  input  logic        [OP_W-1:0]  b,
  output logic signed [ACC_W-1:0] product_c
);

  ext_t a_ext;
  ext_t b_ext;

  // Both operands widened to the full product width so the 34-bit result is exact.
  always_comb begin
    a_ext     = ext_op(a, A_SIGNED);
    b_ext     = ext_op(b, B_SIGNED);
    product_c = acc_t'(a_ext) * acc_t'(b_ext);
  end

endmodule

// File: rtl/mac16_accum.sv
// Registered multiply-accumulate: result = prev_value + a*b, latency 1 or 2 cycles.
module mac16_accum
  import mac16_pkg::*;
#(
  parameter bit A_SIGNED      = 1'b1,
  parameter bit B_SIGNED      = 1'b0,
  parameter bit PIPELINE_MULT = 1'b0
) (
  input  logic                    en,
  input  logic                    clk,
  input  logic signed [ACC_W-1:0] prev_value,
  input  logic        [OP_W-1:0]  a,
  input  logic        [OP_W-1:0]  b,
  input  logic                    reset,
  output logic signed [ACC_W-1:0] result
);

  acc_t product_c;
  acc_t sum_c;

  mac16_mult #(
    .A_SIGNED (A_SIGNED),
    .B_SIGNED (B_SIGNED)
  ) u_mult (
    .a         (a),
    .b         (b),
    .product_c (product_c)
  );

  generate
    if (PIPELINE_MULT) begin : g_pipe
      mac_stage_t stage_r;

      // First stage captures the product and the accumulator input together.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          stage_r <= '0;
        end else if (en) begin
          stage_r.prev <= prev_value;
          stage_r.prod <= product_c;
        end
      end

      assign sum_c = stage_r.prev + stage_r.prod;
    end else begin : g_flat
      assign sum_c = prev_value + product_c;
    end
  endgenerate

  // Sum wraps modulo 2^34 by construction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0;
    end else if (en) begin
      result <= sum_c;
    end
  end

endmodule

// File: tb/tb_mac16_accum.sv
// Randomized self-checking bench for mac16_accum across signedness and pipeline settings.
module tb_mac16_accum;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [33:0] prev_value = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic [33:0] r_sa;   // a signed, b unsigned, latency 1
  logic [33:0] r_ss;   // both signed, latency 1
  logic [33:0] r_uu;   // both unsigned, latency 1
  logic [33:0] r_p;    // a signed, b unsigned, latency 2

  int n_vec = 0;
  int n_err = 0;

  // MAC value per enabled edge since the last reset, one queue per signedness.
  logic [33:0] h_sa[$];
  logic [33:0] h_ss[$];
  logic [33:0] h_uu[$];

  always #5 clk = ~clk;

  mac16_accum #(.A_SIGNED(1'b1), .B_SIGNED(1'b0), .PIPELINE_MULT(1'b0)) dut_sa (
    .en(en), .clk(clk), .prev_value(prev_value), .a(a), .b(b), .reset(reset), .result(r_sa));
  mac16_accum #(.A_SIGNED(1'b1), .B_SIGNED(1'b1), .PIPELINE_MULT(1'b0)) dut_ss (
    .en(en), .clk(clk), .prev_value(prev_value), .a(a), .b(b), .reset(reset), .result(r_ss));
  mac16_accum #(.A_SIGNED(1'b0), .B_SIGNED(1'b0), .PIPELINE_MULT(1'b0)) dut_uu (
    .en(en), .clk(clk), .prev_value(prev_value), .a(a), .b(b), .reset(reset), .result(r_uu));
  mac16_accum #(.A_SIGNED(1'b1), .B_SIGNED(1'b0), .PIPELINE_MULT(1'b1)) dut_p (
    .en(en), .clk(clk), .prev_value(prev_value), .a(a), .b(b), .reset(reset), .result(r_p));

  // Reference: integer arithmetic on the interpreted operand values, kept to 34 bits.
  function automatic logic [33:0] mac_ref(input logic [33:0] pv, input logic [15:0] av,
                                          input logic [15:0] bv, input bit as_, input bit bs_);
    longint pa, pb, pp, acc;
    pa  = as_ ? longint'($signed(av)) : longint'(av);
    pb  = bs_ ? longint'($signed(bv)) : longint'(bv);
    pp  = pa * pb;
    acc = longint'($signed(pv)) + pp;
    return 34'(acc);
  endfunction

  // Result after the latest edge for a given latency: the MAC of the inputs L edges back.
  function automatic logic [33:0] lat_exp(input logic [33:0] q[$], input int l);
    if (q.size() < l) return '0;
    return q[q.size() - l];
  endfunction

  function automatic void hist_clear();
    h_sa.delete();
    h_ss.delete();
    h_uu.delete();
  endfunction

  // One clock edge; records the reference MAC for this edge when it is enabled.
  task automatic tick();
    logic [33:0] pv;
    logic [15:0] av, bv;
    logic        fire;
    pv = prev_value; av = a; bv = b; fire = reset & en;
    @(posedge clk);
    if (fire) begin
      h_sa.push_back(mac_ref(pv, av, bv, 1'b1, 1'b0));
      h_ss.push_back(mac_ref(pv, av, bv, 1'b1, 1'b1));
      h_uu.push_back(mac_ref(pv, av, bv, 1'b0, 1'b0));
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; a = 16'd7; b = 16'd9; prev_value = 34'd5;
    hist_clear();
    repeat (3) tick();
    if (r_sa !== '0) begin n_err++; $display("FAIL reset_hold_sa got %h want 0", r_sa); end
    n_vec++;
    if (r_p !== '0) begin n_err++; $display("FAIL reset_hold_p got %h want 0", r_p); end
    n_vec++;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    en = 1'b1; prev_value = 34'd0; a = 16'd3; b = 16'd5;
    tick();
    if (r_sa !== 34'd15) begin n_err++; $display("FAIL basic_15 got %0d want 15", r_sa); end
    n_vec++;
    prev_value = 34'd15; a = 16'd2; b = 16'd4;
    tick();
    if (r_sa !== 34'd23) begin n_err++; $display("FAIL basic_23 got %0d want 23", r_sa); end
    n_vec++;
  endtask

  task automatic test_sign();
    en = 1'b1; prev_value = 34'd10; a = 16'hFFFE; b = 16'hFFFF;
    tick();
    if (r_sa !== 34'h3_FFFE_000C) begin n_err++; $display("FAIL sign_sa got %h want 3fffe000c", r_sa); end
    n_vec++;
    if (r_ss !== 34'd12) begin n_err++; $display("FAIL sign_ss got %h want 00000000c", r_ss); end
    n_vec++;
    if (r_uu !== 34'h0_FFFD_000C) begin n_err++; $display("FAIL sign_uu got %h want 0fffd000c", r_uu); end
    n_vec++;
  endtask

  task automatic test_hold();
    en = 1'b1; prev_value = 34'd0; a = 16'd3; b = 16'd5;
    tick();
    if (r_sa !== 34'd15) begin n_err++; $display("FAIL hold_pre got %0d want 15", r_sa); end
    n_vec++;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a = 'x; b = 'x; prev_value = 'x;
      end else begin
        a = 16'($urandom()); b = 16'($urandom()); prev_value = 34'({$urandom(), $urandom()});
      end
      tick();
      if (r_sa !== 34'd15) begin n_err++; $display("FAIL hold_cyc%0d got %h want 15", i, r_sa); end
      n_vec++;
      if (r_p !== lat_exp(h_sa, 2)) begin
        n_err++; $display("FAIL hold_p_cyc%0d got %h want %h", i, r_p, lat_exp(h_sa, 2));
      end
      n_vec++;
    end
    en = 1'b1; prev_value = 34'd15; a = 16'd1; b = 16'd1;
    tick();
    if (r_sa !== 34'd16) begin n_err++; $display("FAIL hold_resume got %0d want 16", r_sa); end
    n_vec++;
  endtask

  task automatic test_wrap();
    en = 1'b1; prev_value = 34'h1_FFFF_FFFF; a = 16'd1; b = 16'd1;
    tick();
    if (r_sa !== 34'h2_0000_0000) begin n_err++; $display("FAIL wrap got %h want 200000000", r_sa); end
    n_vec++;
  endtask

  task automatic test_pipeline();
    reset = 1'b0; #2; reset = 1'b1;
    hist_clear();
    en = 1'b1; prev_value = 34'd0; a = 16'd1; b = 16'd100;
    tick();
    if (r_p !== 34'd0) begin n_err++; $display("FAIL pipe_edge1 got %0d want 0", r_p); end
    n_vec++;
    tick();
    if (r_p !== 34'd100) begin n_err++; $display("FAIL pipe_edge2 got %0d want 100", r_p); end
    n_vec++;
  endtask

  task automatic test_feedback();
    logic [15:0] taps[4];
    logic [15:0] smps[4];
    logic [33:0] acc;
    taps = '{16'd1, 16'd2, 16'd3, 16'd4};
    smps = '{16'd10, 16'd20, 16'd30, 16'd40};
    acc = '0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prev_value = (i == 0) ? 34'd0 : r_p;
      a = taps[i]; b = smps[i];
      repeat (2) tick();
      acc = acc + 34'(taps[i] * smps[i]);
      if (r_p !== acc) begin n_err++; $display("FAIL feedback_tap%0d got %0d want %0d", i, r_p, acc); end
      n_vec++;
    end
    if (r_p !== 34'd300) begin n_err++; $display("FAIL feedback_final got %0d want 300", r_p); end
    n_vec++;
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom()); b = 16'($urandom()); prev_value = 34'({$urandom(), $urandom()});
      tick();
    end
    #2; reset = 1'b0; #1;
    hist_clear();
    if ({r_sa, r_ss, r_uu, r_p} !== '0) begin
      n_err++; $display("FAIL async_clear got %h %h %h %h want all 0", r_sa, r_ss, r_uu, r_p);
    end
    n_vec++;
    tick();
    reset = 1'b1; prev_value = 34'd1; a = 16'd5; b = 16'd6;
    tick();
    if (r_sa !== 34'd31) begin n_err++; $display("FAIL async_first_sa got %0d want 31", r_sa); end
    n_vec++;
    if (r_p !== 34'd0) begin n_err++; $display("FAIL async_first_p got %0d want 0", r_p); end
    n_vec++;
    tick();
    if (r_p !== 34'd31) begin n_err++; $display("FAIL async_second_p got %0d want 31", r_p); end
    n_vec++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(3, 0) != 0);
      a = 16'($urandom()); b = 16'($urandom());
      if ($urandom_range(3, 0) == 0) prev_value = r_sa;
      else prev_value = 34'({$urandom(), $urandom()});
      tick();
      if (r_sa !== lat_exp(h_sa, 1)) begin
        n_err++; $display("FAIL rand_sa cyc%0d got %h want %h", i, r_sa, lat_exp(h_sa, 1));
      end
      n_vec++;
      if (r_ss !== lat_exp(h_ss, 1)) begin
        n_err++; $display("FAIL rand_ss cyc%0d got %h want %h", i, r_ss, lat_exp(h_ss, 1));
      end
      n_vec++;
      if (r_uu !== lat_exp(h_uu, 1)) begin
        n_err++; $display("FAIL rand_uu cyc%0d got %h want %h", i, r_uu, lat_exp(h_uu, 1));
      end
      n_vec++;
      if (r_p !== lat_exp(h_sa, 2)) begin
        n_err++; $display("FAIL rand_p cyc%0d got %h want %h", i, r_p, lat_exp(h_sa, 2));
      end
      n_vec++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_hold();
    test_wrap();
    test_pipeline();
    test_feedback();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac16_accum.md
Name: mac16_accum

Overview:
- 16x16 multiply-accumulate used by the FIR datapath (fakedsp-style tap loop).
- Computes result = prev_value + a*b, registered; a is the signed filter coefficient, b the unsigned sample.
- Behavioural stand-in for the iCE40 SB_MAC16 primitive (MAC16).
- Accumulation is closed externally by feeding result back into prev_value.

Parameters:
- A_SIGNED, 1, operand a is two's complement when 1, unsigned when 0.
- B_SIGNED, 0, operand b is two's complement when 1, unsigned when 0.
- PIPELINE_MULT, 0:
  - 0: single register stage, latency 1.
  - 1: extra product/prev register stage, latency 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  clock enable; all internal registers advance only when high.
- prev_value  in  34  accumulator input, two's complement.
- a  in  16  coefficient operand.
- b  in  16  sample operand.
- result  out  34  registered prev_value + a*b, two's complement.
- Positional instantiation order is fixed: en, clk, prev_value, a, b, reset, result.

Behaviour:
- Reset:
  - reset=0 asynchronously clears result and every pipeline register to 0, regardless of clk/en.
  - Reset is held while low.
  - First update occurs on the first rising clk edge with reset=1 and en=1.
  - Reset asserted mid-operation discards in-flight data; no partial result appears after release.
- Operand extension:
  - a is extended to 17 bits: sign-extend if A_SIGNED, zero-extend otherwise.
  - b is extended to 17 bits the same way, controlled by B_SIGNED.
- Product: 17x17 signed multiply, giving a 34-bit product that is exact for all operand combinations.
- Sum: prev_value + product, computed modulo 2^34. No saturation, no overflow flag; wrap-around is silent.
- PIPELINE_MULT=0: on posedge with en=1, result <= prev_value + product(a,b). Latency 1 cycle.
- PIPELINE_MULT=1:
  - Stage 1 (en=1): prod_r <= product(a,b); prev_r <= prev_value.
  - Stage 2 (en=1): result <= prev_r + prod_r.
  - Latency 2 cycles. Both stages share en.
- en=0: all registers hold their value; input changes have no effect.
- Combinational paths: none from inputs to result.
- X on inputs while en=0 must not propagate.

Decomposition:
- Package mac16_pkg:
  - OP_W=16, EXT_W=17, ACC_W=34.
  - typedefs: op_t logic[15:0], acc_t logic signed[33:0].
- One sub-module: mac16_mult.
  - Signedness-aware operand extension plus 17x17 multiply.
  - Purely combinational; parameters A_SIGNED and B_SIGNED.
- mac16_accum holds the adder and the register stages.

Test Plan:
- Reset: hold reset=0 with a=7, b=9, en=1 and toggle clk -> result stays 0. Assert reset=0 mid-stream, asynchronously between edges -> result becomes 0 immediately.
- Basic MAC (PIPELINE_MULT=0): a=3, b=5, prev_value=0, en=1 -> result=15 after one edge. Then prev_value=15, a=2, b=4 -> result=23.
- Signedness: a=16'hFFFE (-2), b=16'hFFFF (65535, unsigned), prev_value=10 -> result=34'h3_FFFE_000C (-131060). With B_SIGNED=1, same inputs -> result=12.
- Hold: after result=15, set en=0 and change a, b, prev_value for 5 cycles -> result stays 15. Re-assert en -> result updates next edge.
- Wrap: prev_value=34'h1_FFFF_FFFF, a=1, b=1 -> result=34'h2_0000_0000 (wraps negative, no error).
- Pipeline + feedback (PIPELINE_MULT=1):
  - a=1, b=100 with en=1 -> result=100 exactly 2 edges later.
  - 4-tap loop with taps {1,2,3,4} and samples {10,20,30,40}, prev_value fed from result at matching latency -> final result=300.
